// File: rtl/regfile_mp.sv
// Multi-port integer register file with async reset-to-zero, optional
// hardwired r0, optional write-to-read bypass and a one-register-per-cycle
// clear engine for flush/context reset.

// One read lane: stored value, optionally overridden by a same-cycle write.
module regfile_mp_rdport #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                i_reset,
  input  logic [AW-1:0]       rs_addr,
  input  logic [XLEN-1:0]     stored,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_en,
  output logic [XLEN-1:0]     rs_data
);
  // Ascending scan so the highest-index matching writer wins the bypass.
  always_comb begin
    rs_data = stored;
    if (BYPASS != 0) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == rs_addr))
          rs_data = wr_data[j*XLEN +: XLEN];
      end
    end
    // Reset forces zero even if a bypassed write is presented.
    if (i_reset || ((ZERO_R0 != 0) && (rs_addr == '0)))
      rs_data = '0;
  end

  logic unused_rd;
  assign unused_rd = ^{wr_addr, wr_data, wr_en};
endmodule

module regfile_mp #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int AW      = $clog2(NREGS),
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NRD*AW-1:0]   i_rs_addr,
  output logic [NRD*XLEN-1:0] o_rs_data,
  input  logic [NWR*AW-1:0]   i_rd_addr,
  input  logic [NWR*XLEN-1:0] i_rd_data,
  input  logic [NWR-1:0]      i_rd_wren,
  input  logic                i_clr,
  output logic                o_busy,
  output logic                o_clr_done
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [0:0]                 state;
  logic [AW-1:0]              idx;
  logic                       clr_done_q;
  logic [NWR-1:0]             wr_en_q;

  assign o_busy     = (state == ST_CLEAR);
  assign o_clr_done = clr_done_q;
  // Writes are dropped (not queued) for the whole clear sequence.
  assign wr_en_q    = i_rd_wren & {NWR{~o_busy}};

  // Clear sequencer: walk idx from first clearable register to NREGS-1.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (i_clr) begin
          state <= ST_CLEAR;
          idx   <= (ZERO_R0 != 0) ? AW'(1) : '0;
        end
      end else begin
        idx <= idx + 1'b1;
        if (idx == AW'(NREGS-1)) begin
          state      <= ST_IDLE;
          idx        <= '0;
          clr_done_q <= 1'b1;
        end
      end
    end
  end

  // Storage: clear engine owns the array while busy, else port writes with
  // later ports overriding earlier ones on an address collision.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      regs <= '0;
    end else if (o_busy) begin
      regs[idx] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en_q[j] && !((ZERO_R0 != 0) && (i_rd_addr[j*AW +: AW] == '0)))
          regs[i_rd_addr[j*AW +: AW]] <= i_rd_data[j*XLEN +: XLEN];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_mp_rdport #(
      .XLEN(XLEN), .AW(AW), .NWR(NWR), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
    ) u_rd (
      .i_reset (i_reset),
      .rs_addr (i_rs_addr[k*AW +: AW]),
      .stored  (regs[i_rs_addr[k*AW +: AW]]),
      .wr_addr (i_rd_addr),
      .wr_data (i_rd_data),
      .wr_en   (wr_en_q),
      .rs_data (o_rs_data[k*XLEN +: XLEN])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default config (u_a) and a 64-bit/16-entry/3R1W,
// ordinary-r0, no-bypass config (u_b).
module tb_regfile_mp;
  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // DUT A: defaults
  logic         rst_a, clr_a, busy_a, done_a;
  logic [9:0]   rs_a, wa_a;
  logic [63:0]  rdat_a, wd_a;
  logic [1:0]   we_a;
  regfile_mp u_a (
    .i_clk(i_clk), .i_reset(rst_a), .i_rs_addr(rs_a), .o_rs_data(rdat_a),
    .i_rd_addr(wa_a), .i_rd_data(wd_a), .i_rd_wren(we_a), .i_clr(clr_a),
    .o_busy(busy_a), .o_clr_done(done_a)
  );

  // DUT B: sweep config
  logic          rst_b, clr_b, busy_b, done_b;
  logic [11:0]   rs_b;
  logic [191:0]  rdat_b;
  logic [3:0]    wa_b;
  logic [63:0]   wd_b;
  logic [0:0]    we_b;
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(1), .ZERO_R0(0), .BYPASS(0)) u_b (
    .i_clk(i_clk), .i_reset(rst_b), .i_rs_addr(rs_b), .o_rs_data(rdat_b),
    .i_rd_addr(wa_b), .i_rd_data(wd_b), .i_rd_wren(we_b), .i_clr(clr_b),
    .o_busy(busy_b), .o_clr_done(done_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  string       sb_tag[$];
  int          sb_dut[$];
  int          sb_port[$];
  logic [63:0] sb_exp[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rd_a(input int p, input int a, input logic [63:0] e, input string tag);
    rs_a[p*5 +: 5] = 5'(a);
    sb_tag.push_back(tag); sb_dut.push_back(0); sb_port.push_back(p); sb_exp.push_back(e);
  endtask

  task automatic rd_b(input int p, input int a, input logic [63:0] e, input string tag);
    rs_b[p*4 +: 4] = 4'(a);
    sb_tag.push_back(tag); sb_dut.push_back(1); sb_port.push_back(p); sb_exp.push_back(e);
  endtask

  function automatic logic [63:0] dout(input int d, input int p);
    if (d == 0) return {32'b0, rdat_a[p*32 +: 32]};
    return rdat_b[p*64 +: 64];
  endfunction

  // Let combinational reads settle, then retire every pending expectation.
  task automatic drain();
    string t; int d; int p; logic [63:0] e;
    #1;
    while (sb_exp.size() > 0) begin
      t = sb_tag.pop_front(); d = sb_dut.pop_front();
      p = sb_port.pop_front(); e = sb_exp.pop_front();
      chk(t, dout(d, p), e);
    end
  endtask

  task automatic wr_a(input int j, input int a, input logic [31:0] d);
    we_a[j] = 1'b1;
    wa_a[j*5 +: 5]  = 5'(a);
    wd_a[j*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, dones;
    rst_a = 1; clr_a = 0; rs_a = '0; wa_a = '0; wd_a = '0; we_a = '0;
    rst_b = 1; clr_b = 0; rs_b = '0; wa_b = '0; wd_b = '0; we_b = '0;
    tick(); tick();

    // Reset state
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    wr_a(0, 5, 32'hDEADBEEF);
    rd_a(0, 5, 64'd0, "rst_bypass_masked");
    rd_a(1, 9, 64'd0, "rst_r9");
    drain();
    we_a = '0;
    rst_a = 0; rst_b = 0;
    tick();

    // Basic write / read, r0 hardwired
    wr_a(0, 5, 32'hDEADBEEF);
    tick(); we_a = '0;
    rd_a(0, 5, 64'hDEADBEEF, "wr_r5");
    drain();
    wr_a(1, 0, 32'h1234);
    rd_a(1, 0, 64'd0, "r0_bypass");
    drain();
    tick(); we_a = '0;
    rd_a(1, 0, 64'd0, "r0_zero");
    drain();

    // Conflict: highest port wins, bypass and committed
    wr_a(0, 7, 32'h11); wr_a(1, 7, 32'h22);
    rd_a(1, 7, 64'h22, "conf_byp1");
    rd_a(0, 7, 64'h22, "conf_byp0");
    drain();
    tick(); we_a = '0;
    rd_a(1, 7, 64'h22, "conf_edge");
    drain();
    wr_a(0, 9, 32'h99); wr_a(1, 10, 32'hAA);
    rd_a(0, 9, 64'h99, "byp_port0");
    rd_a(1, 10, 64'hAA, "byp_port1");
    drain();
    tick(); we_a = '0;

    // Fill r1..r31 with index
    for (int i = 1; i < 32; i++) begin
      wr_a(0, i, 32'(i));
      tick();
    end
    we_a = '0;
    rd_a(0, 31, 64'd31, "fill31");
    rd_a(1, 9, 64'd9, "fill9");
    drain();

    // Sequenced clear; write committed on the start edge is wiped
    clr_a = 1; wr_a(0, 9, 32'hAAAA);
    tick(); clr_a = 0; we_a = '0;
    chk("clr_busy_start", 64'(busy_a), 64'd1);
    n = 0; dones = 0;
    while (busy_a && n < 100) begin
      if (done_a) dones++;
      if (n == 5) clr_a = 1;
      if (n == 10) begin
        wr_a(0, 3, 32'hFFFF); wr_a(1, 20, 32'hEEEE);
        rd_a(0, 3, 64'd0, "busy_r3_cleared");
        rd_a(1, 20, 64'd20, "busy_nobyp_r20");
        drain();
      end
      n++;
      tick();
      we_a = '0; clr_a = 0;
    end
    chk("clr_cycles", 64'(n), 64'd31);
    chk("clr_done_early", 64'(dones), 64'd0);
    chk("clr_done", 64'(done_a), 64'd1);
    tick();
    chk("clr_done_pulse", 64'(done_a), 64'd0);
    chk("clr_idle", 64'(busy_a), 64'd0);
    rd_a(0, 3, 64'd0, "busy_wr_lost");
    drain();
    for (int a = 0; a < 32; a++) begin
      rd_a(a % 2, a, 64'd0, $sformatf("clr_zero_r%0d", a));
      drain();
    end

    // Clear abort by reset
    wr_a(0, 4, 32'd4); wr_a(1, 30, 32'd30);
    tick(); we_a = '0;
    rd_a(1, 30, 64'd30, "pre_abort_r30");
    drain();
    clr_a = 1; tick(); clr_a = 0;
    repeat (10) tick();
    chk("abort_busy_pre", 64'(busy_a), 64'd1);
    #1 rst_a = 1;
    #1;
    chk("abort_busy", 64'(busy_a), 64'd0);
    rd_a(0, 30, 64'd0, "abort_r30");
    rd_a(1, 4, 64'd0, "abort_r4");
    drain();
    tick(); rst_a = 0;
    dones = 0;
    repeat (5) begin
      if (done_a || busy_a) dones++;
      tick();
    end
    chk("abort_nodone", 64'(dones), 64'd0);
    clr_a = 1; tick(); clr_a = 0;
    n = 0;
    while (busy_a && n < 100) begin n++; tick(); end
    chk("reclr_cycles", 64'(n), 64'd31);
    chk("reclr_done", 64'(done_a), 64'd1);

    // Sweep config: ordinary r0, no bypass, 16 entries
    we_b = 1'b1; wa_b = 4'd0; wd_b = 64'h1234;
    rd_b(2, 0, 64'd0, "b_r0_nobyp");
    drain();
    tick(); we_b = '0;
    rd_b(2, 0, 64'h1234, "b_r0");
    drain();
    we_b = 1'b1; wa_b = 4'd5; wd_b = 64'hDEADBEEF_CAFEF00D;
    rd_b(1, 5, 64'd0, "b_old");
    drain();
    tick(); we_b = '0;
    rd_b(1, 5, 64'hDEADBEEF_CAFEF00D, "b_new");
    rd_b(0, 0, 64'h1234, "b_r0_keep");
    drain();
    we_b = 1'b1; wa_b = 4'd15; wd_b = 64'hF;
    tick(); we_b = '0;
    rd_b(2, 15, 64'hF, "b_r15");
    drain();
    clr_b = 1; tick(); clr_b = 0;
    n = 0; dones = 0;
    while (busy_b && n < 100) begin
      if (done_b) dones++;
      n++; tick();
    end
    chk("b_clr_cycles", 64'(n), 64'd16);
    chk("b_clr_done_early", 64'(dones), 64'd0);
    chk("b_clr_done", 64'(done_b), 64'd1);
    rd_b(0, 0, 64'd0, "b_clr_r0");
    rd_b(1, 5, 64'd0, "b_clr_r5");
    rd_b(2, 15, 64'd0, "b_clr_r15");
    drain();
    tick();
    chk("b_clr_done_pulse", 64'(done_b), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
